// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumed by the LSU FSM and its timeout counter.
package cpu_mem_pkg;

   // LSU FSM states: IDLE waits for an access, REQ holds the bus request,
   // RESP waits for the response, DONE releases the pipeline for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // ResultSrcM encodings from the M stage.
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   // Cycles allowed in REQ+RESP before the access is abandoned as a fault.
   localparam int DEFAULT_TIMEOUT = 255;

   // Word accesses only: the two byte-offset bits must be zero.
   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-bus port of the LSU: request channel with valid/ready plus a response strobe.
// Wires only, zero latency.
// Request backpressure is bus_req_ready; the response channel cannot be stalled.
interface mem_stage_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_req_we;
   logic [ADDR_W-1:0] bus_req_addr;
   logic [DATA_W-1:0] bus_req_wdata;
   logic              bus_rsp_valid;
   logic [DATA_W-1:0] bus_rsp_rdata;

   // The LSU drives requests and receives responses.
   modport master (
      output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
      input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
   );

   // The interconnect / memory side.
   modport slave (
      input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata,
      output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
   );
endinterface

// File: rtl/lsu_timeout_counter.sv
// Counts cycles an access spends in REQ+RESP and flags the cycle that uses up the budget.
// tc is combinational from the registered count: it is high in the TIMEOUT-th enabled cycle.
// No backpressure; clear has priority over enable.
module lsu_timeout_counter
   import cpu_mem_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tc
);
   localparam int            W    = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   // Count enabled cycles; restart from zero whenever a new access begins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   // The enabled cycle that brings the count to TIMEOUT is the last one allowed.
   assign tc = en && (count == LAST);

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: turns M-stage loads/stores into one valid/ready bus transaction each.
// Latency: a word access with immediate ready and response stalls 3 cycles (IDLE, REQ, RESP), releases in DONE.
// Holds mem_stall while waiting on bus_req_ready or bus_rsp_valid; a timeout aborts the access with mem_fault.
module mem_stage_lsu
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [1:0]        ResultSrcM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   mem_stage_lsu_if.master   bus,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              mem_stall,
   output logic              mem_fault
);

   lsu_state_t        state;
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              discard;

   logic access;
   logic aligned;
   logic start;
   logic misaligned;
   logic busy;
   logic tc;
   logic suppress;

   assign access     = MemWriteM | (ResultSrcM == RESULT_MEM);
   assign aligned    = is_word_aligned(ALUResultM[1:0]);
   assign start      = (state == IDLE) && access && aligned && !flush;
   assign misaligned = (state == IDLE) && access && !aligned && !flush;
   assign busy       = (state == REQ) || (state == RESP);
   // A flushed instruction, whether flushed earlier or this very cycle, reports nothing.
   assign suppress   = discard || flush;

   // Stall starts combinationally in IDLE so the EX/MEM register holds the access steady.
   assign mem_stall  = start || busy;

   assign bus.bus_req_valid = req_valid;
   assign bus.bus_req_we    = req_we;
   assign bus.bus_req_addr  = req_addr;
   assign bus.bus_req_wdata = req_wdata;

   lsu_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .en    (busy),
      .tc    (tc)
   );

   // Transaction FSM with registered bus request, load data, fault pulse and discard flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_valid <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         ReadDataM <= '0;
         mem_fault <= 1'b0;
         discard   <= 1'b0;
      end else begin
         mem_fault <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  req_valid <= 1'b1;
                  req_we    <= MemWriteM;
                  req_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                  req_wdata <= WriteDataM;
                  state     <= REQ;
               end else if (misaligned) begin
                  mem_fault <= 1'b1;
               end
            end
            REQ: begin
               // Valid stays up through a flush; only the result is thrown away.
               if (flush) discard <= 1'b1;
               // Timeout wins over a same-cycle ready: the interconnect abandons the request.
               if (tc) begin
                  req_valid <= 1'b0;
                  mem_fault <= !suppress;
                  state     <= DONE;
               end else if (bus.bus_req_ready) begin
                  req_valid <= 1'b0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (flush) discard <= 1'b1;
               // A response arriving in the last allowed cycle still completes normally.
               if (bus.bus_rsp_valid) begin
                  if (!req_we && !suppress) ReadDataM <= bus.bus_rsp_rdata;
                  state <= DONE;
               end else if (tc) begin
                  mem_fault <= !suppress;
                  state     <= DONE;
               end
            end
            DONE: begin
               discard <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A response before the request has been accepted breaks the bus protocol.
   rsp_in_req_a: assert property (@(posedge clk) disable iff (!rst_n)
      !((state == REQ) && bus.bus_rsp_valid));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: table of accesses driven through a small bus responder,
// bus requests checked against a scoreboard queue, plus hand-written reset sequences.
module tb_mem_stage_lsu;
   import cpu_mem_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        mem_stall;
   logic        mem_fault;

   mem_stage_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_stage_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .ResultSrcM (ResultSrcM),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .bus        (bus),
      .ReadDataM  (ReadDataM),
      .mem_stall  (mem_stall),
      .mem_fault  (mem_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          store;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdy_dly;    // valid cycles before ready is given
      int          rsp_dly;    // RESP cycle carrying the response, 0 = never
      bit          flush_idle;
      bit          flush_resp;
      int          exp_stall;
      int          exp_fault;
      int          exp_acc;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   req_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] model_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      MemWriteM         = 1'b0;
      ResultSrcM        = RESULT_ALU;
      ALUResultM        = '0;
      WriteDataM        = '0;
      flush             = 1'b0;
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int   stall_cnt = 0;
      int   fault_cnt = 0;
      int   acc_cnt   = 0;
      int   rdy_wait  = 0;
      int   resp_cyc  = 0;
      bit   in_resp   = 0;
      bit   acc_edge  = 0;
      bit   fin       = 0;
      bit   seen      = 0;
      bit   unstable  = 0;
      bit   tail_bad  = 0;
      req_t cap;
      req_t exp_r;

      for (int c = 0; c < 60 && !fin; c++) begin
         @(negedge clk);
         if (c == 0) begin
            MemWriteM  = v.store;
            ResultSrcM = v.store ? RESULT_ALU : RESULT_MEM;
            ALUResultM = v.addr;
            WriteDataM = v.wdata;
            bus.bus_rsp_rdata = v.rdata;
            if (v.exp_acc != 0) sb.push_back('{we: v.store, addr: v.addr, wdata: v.wdata});
         end
         if (acc_edge) begin
            in_resp  = 1;
            resp_cyc = 0;
            acc_edge = 0;
         end
         if (in_resp) resp_cyc++;
         bus.bus_rsp_valid = in_resp && (v.rsp_dly != 0) && (resp_cyc == v.rsp_dly);
         bus.bus_req_ready = bus.bus_req_valid && (rdy_wait >= v.rdy_dly);
         if (bus.bus_req_valid) rdy_wait++;
         flush = (c == 0) ? v.flush_idle : (v.flush_resp && in_resp && resp_cyc == 1);
         #1;
         if (mem_stall) stall_cnt++;
         if (mem_fault) fault_cnt++;
         if (bus.bus_req_valid) begin
            if (!seen) begin
               seen = 1;
               cap  = '{we: bus.bus_req_we, addr: bus.bus_req_addr, wdata: bus.bus_req_wdata};
            end else if (cap.we !== bus.bus_req_we || cap.addr !== bus.bus_req_addr ||
                         cap.wdata !== bus.bus_req_wdata) begin
               unstable = 1;
            end
         end
         if (bus.bus_req_valid && bus.bus_req_ready) begin
            acc_cnt++;
            acc_edge = 1;
            if (sb.size() == 0) begin
               check({v.name, "_unexpected_req"}, 32'd1, 32'd0);
            end else begin
               exp_r = sb.pop_front();
               check({v.name, "_req_we"}, 32'(bus.bus_req_we), 32'(exp_r.we));
               check({v.name, "_req_addr"}, bus.bus_req_addr, exp_r.addr);
               if (exp_r.we) check({v.name, "_req_wdata"}, bus.bus_req_wdata, exp_r.wdata);
            end
         end
         if (!mem_stall) fin = 1;
      end

      // Two cycles with the slot empty catch late fault pulses and stray requests.
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         if (mem_fault) fault_cnt++;
         if (mem_stall || bus.bus_req_valid) tail_bad = 1;
      end

      if (!v.store && v.addr[1:0] == 2'b00 && !v.flush_idle && !v.flush_resp &&
          v.rsp_dly != 0 && v.exp_acc != 0)
         model_rd = v.rdata;

      check({v.name, "_completed"}, 32'(fin), 32'd1);
      check({v.name, "_stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
      check({v.name, "_fault_pulses"}, 32'(fault_cnt), 32'(v.exp_fault));
      check({v.name, "_accepted"}, 32'(acc_cnt), 32'(v.exp_acc));
      check({v.name, "_sb_left"}, 32'(sb.size()), 32'd0);
      check({v.name, "_read_data"}, ReadDataM, model_rd);
      check({v.name, "_quiet_after"}, 32'(tail_bad), 32'd0);
      if (seen) check({v.name, "_req_stable"}, 32'(unstable), 32'd0);
      sb.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
      check({tag, "_req_valid"}, 32'(bus.bus_req_valid), 32'd0);
      check({tag, "_req_we"}, 32'(bus.bus_req_we), 32'd0);
      check({tag, "_req_addr"}, bus.bus_req_addr, 32'd0);
      check({tag, "_req_wdata"}, bus.bus_req_wdata, 32'd0);
      check({tag, "_read_data"}, ReadDataM, 32'd0);
      check({tag, "_stall"}, 32'(mem_stall), 32'd0);
      check({tag, "_fault"}, 32'(mem_fault), 32'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{"ld_basic",      1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0,  1, 1'b0, 1'b0, 3, 0, 1};
      vecs[1] = '{"st_slow_ready", 1'b1, 32'h0000_0204, 32'hCAFE_F00D,  32'hFFFF_FFFF, 4,  1, 1'b0, 1'b0, 7, 0, 1};
      vecs[2] = '{"ld_misaligned", 1'b0, 32'h0000_0102, 32'h0,          32'h1111_2222, 0,  1, 1'b0, 1'b0, 0, 1, 0};
      vecs[3] = '{"st_misaligned", 1'b1, 32'h0000_0301, 32'h5555_AAAA,  32'h0,         0,  1, 1'b0, 1'b0, 0, 1, 0};
      vecs[4] = '{"ld_no_rsp",     1'b0, 32'h0000_0400, 32'h0,          32'h1111_1111, 0,  0, 1'b0, 1'b0, 9, 1, 1};
      vecs[5] = '{"ld_no_ready",   1'b0, 32'h0000_0404, 32'h0,          32'h2222_2222, 20, 0, 1'b0, 1'b0, 9, 1, 0};
      vecs[6] = '{"ld_late_ok",    1'b0, 32'h0000_0408, 32'h0,          32'h0BAD_F00D, 1,  5, 1'b0, 1'b0, 8, 0, 1};
      vecs[7] = '{"ld_flush_resp", 1'b0, 32'h0000_010C, 32'h0,          32'h1234_5678, 0,  2, 1'b0, 1'b1, 4, 0, 1};
      vecs[8] = '{"st_flush_idle", 1'b1, 32'h0000_0208, 32'h7777_8888,  32'h0,         0,  1, 1'b1, 1'b0, 0, 0, 0};
      vecs[9] = '{"ld_slow",       1'b0, 32'h0000_0500, 32'h0,          32'hA5A5_A5A5, 3,  3, 1'b0, 1'b0, 8, 0, 1};

      rst_n = 1'b0;
      idle_inputs();
      bus.bus_rsp_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset while a load waits in RESP: everything returns to zero at once.
      @(negedge clk);
      MemWriteM  = 1'b0;
      ResultSrcM = RESULT_MEM;
      ALUResultM = 32'h0000_0700;
      #1;
      @(negedge clk);
      bus.bus_req_ready = bus.bus_req_valid;
      #1;
      check("midrst_req_seen", 32'(bus.bus_req_valid), 32'd1);
      @(negedge clk);
      bus.bus_req_ready = 1'b0;
      #1;
      check("midrst_stall_in_resp", 32'(mem_stall), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      model_rd = '0;
      #1;
      check_reset_state("midrst");

      run_vec('{"ld_after_rst", 1'b0, 32'h0000_0000, 32'h0, 32'h600D_CAFE, 0, 1, 1'b0, 1'b0, 3, 0, 1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, %0d checks done", n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It sits directly downstream of the execute/memory pipeline register and consumes its M-stage outputs. It converts load and store instructions into a valid/ready data-bus transaction with variable-latency response. While a transaction is outstanding it raises mem_stall to freeze the pipeline, and it presents the load data to the memory/writeback register.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, data width (word accesses only)
TIMEOUT, 255, max cycles in REQ+RESP before the access is aborted as a fault

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  exception flush; discards the result of the current M instruction
ResultSrcM  in  2  2'b01 = load
MemWriteM  in  1  store
ALUResultM  in  ADDR_W  effective address
WriteDataM  in  DATA_W  store data
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_W  word address (low 2 bits always 0)
bus_req_wdata  out  DATA_W  store data
bus_rsp_valid  in  1  response/ack, earliest one cycle after acceptance
bus_rsp_rdata  in  DATA_W  load data
ReadDataM  out  DATA_W  load result, held until the next completed load
mem_stall  out  1  drives stall of the EX/MEM register and all upstream stages
mem_fault  out  1  one-cycle pulse: misaligned address or timeout

Behaviour:
- Reset is synchronous, active-low, on rst_n; clock is clk. On reset: state=IDLE; bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, ReadDataM, mem_fault, the timeout counter and the discard flag all return to 0.
- access = MemWriteM | (ResultSrcM==2'b01). aligned = (ALUResultM[1:0]==0).
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - access & aligned & !flush: mem_stall=1 (combinational); latch addr, wdata and we into the bus registers; next state REQ.
  - access & !aligned & !flush: no bus request; mem_fault=1 next cycle; mem_stall=0; stay in IDLE.
  - no access, or flush asserted: mem_stall=0; stay in IDLE.
- REQ: bus_req_valid=1 with stable addr/we/wdata until bus_req_ready. Once valid is raised it is never withdrawn, even on flush. mem_stall=1. On ready, go to RESP.
- RESP: mem_stall=1. On bus_rsp_valid:
  - if load and not discarded, ReadDataM <= bus_rsp_rdata;
  - go to DONE.
- DONE: mem_stall=0 for exactly one cycle so the pipeline advances; next state IDLE. A new access seen in IDLE on the following cycle starts fresh.
- Minimum latency with ready and rsp both immediate: stall in IDLE, REQ and RESP (3 cycles), release in DONE. A load therefore costs 3 stall cycles.
- Timeout: the counter clears on leaving IDLE and increments each cycle in REQ/RESP. At count==TIMEOUT:
  - go to DONE and pulse mem_fault;
  - ReadDataM is left unchanged;
  - bus_req_valid is dropped. The interconnect contract is that it abandons the transaction.
- Flush during REQ/RESP sets a discard flag. The bus transaction still completes; a store that was already issued is performed. ReadDataM is not updated and no fault is raised. The flag clears in DONE.
- Flush in DONE has no effect on FSM sequencing.
- A response arriving in REQ (before ready) is illegal. An assertion flags it.
- Reset mid-transaction: the FSM is forced to IDLE immediately. Outstanding bus state is the interconnect's responsibility; it is reset by the same rst_n.

Decomposition:
- Package cpu_mem_pkg:
  - state enum (IDLE/REQ/RESP/DONE);
  - RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10;
  - the default TIMEOUT value.
- One sub-module, lsu_timeout_counter: clear, enable, and a terminal-count flag at TIMEOUT.

Test Plan:
- Load from 0x100, ready immediate, rsp one cycle later with 0xDEADBEEF: mem_stall high for 3 cycles, low in DONE, then ReadDataM=0xDEADBEEF, bus_req_we=0.
- Store 0xCAFEF00D to 0x204, ready delayed 4 cycles: req_valid and addr/wdata stable throughout, we=1, mem_stall high until DONE, ReadDataM unchanged.
- Load from 0x102: no bus_req_valid, mem_fault pulses once, mem_stall never asserted.
- Load with ready but rsp never returned, TIMEOUT=8: mem_fault pulses after 8 cycles in REQ+RESP, FSM passes through DONE to IDLE, ReadDataM unchanged.
- Flush asserted in RESP of a load returning 0x12345678: transaction completes, ReadDataM keeps its old value, no fault; a flush asserted in IDLE with a pending store issues no request.
- rst_n low during RESP: next cycle state=IDLE, all outputs 0; a subsequent load to 0x0 completes normally.
